// File: rtl/intf_stream_fifo_if.sv
// Valid/ready/data stream bundle shared by producer and consumer sides of the FIFO.
// The sink receives beats (drives ready); the source emits beats (drives valid and data).
interface stream_intf #(
   parameter int WIDTH = 8
) ();
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport sink   (input valid, input data, output ready);
   modport source (output valid, output data, input ready);
endinterface

// File: rtl/intf_stream_fifo.sv
// First-word-fall-through FIFO between two stream_intf ports.
// Also reports occupancy and a sticky high-water mark.
module intf_stream_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   stream_intf.sink      in,
   stream_intf.source    out,
   output logic [CW-1:0] count,
   output logic [CW-1:0] max_count
);
   localparam int            AW   = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    max_q, max_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             not_full, not_empty, push, pop;

   // Handshake flags come only from registered occupancy, so out.ready never reaches in.ready.
   assign not_full  = (count_q != FULL);
   assign not_empty = (count_q != '0);
   assign push      = in.valid && not_full;
   assign pop       = not_empty && out.ready;

   assign in.ready  = not_full;
   assign out.valid = not_empty;
   assign out.data  = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign max_count = max_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      max_d = (count_d > max_q) ? count_d : max_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         max_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         max_q    <= max_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in.data;
   end
endmodule

// File: tb/tb_intf_stream_fifo.sv
// Scoreboard bench for intf_stream_fifo: an 8x4 instance and a 32x8 instance.
// Accepted beats are queued at the producer side and compared as the consumer pops them.
module tb_intf_stream_fifo;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   stream_intf #(.WIDTH(8))  in_a ();
   stream_intf #(.WIDTH(8))  out_a ();
   stream_intf #(.WIDTH(32)) in_b ();
   stream_intf #(.WIDTH(32)) out_b ();
   logic [2:0] count_a, max_a;
   logic [3:0] count_b, max_b;

   intf_stream_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a), .count(count_a), .max_count(max_a));
   intf_stream_fifo #(.WIDTH(32), .DEPTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b), .count(count_b), .max_count(max_b));

   logic [31:0] q_a[$];
   logic [31:0] q_b[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_a.delete();
      q_b.delete();
   endtask

   // Inputs change at posedge+1, so the negedge sees exactly what the next edge will act on.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_a.valid && out_a.ready) begin
            if (q_a.size() == 0) check_val("a_pop_unexpected", 32'(out_a.data), 32'hFFFF_FFFF);
            else check_val("a_data", 32'(out_a.data), q_a.pop_front());
         end
         if (in_a.valid && in_a.ready) q_a.push_back(32'(in_a.data));
         if (out_b.valid && out_b.ready) begin
            if (q_b.size() == 0) check_val("b_pop_unexpected", out_b.data, ~out_b.data);
            else check_val("b_data", out_b.data, q_b.pop_front());
         end
         if (in_b.valid && in_b.ready) q_b.push_back(in_b.data);
      end
   end

   initial begin
      rst_n = 1'b0;
      in_a.valid = 1'b0; in_a.data = '0; out_a.ready = 1'b0;
      in_b.valid = 1'b0; in_b.data = '0; out_b.ready = 1'b0;

      // Reset / idle
      do_reset();
      check_val("rst_count", 32'(count_a), 32'd0);
      check_val("rst_max", 32'(max_a), 32'd0);
      check_val("rst_out_valid", 32'(out_a.valid), 32'd0);
      check_val("rst_in_ready", 32'(in_a.ready), 32'd1);

      // Fill then drain
      for (int i = 0; i < 4; i++) begin
         in_a.valid = 1'b1;
         in_a.data  = 8'(8'h11 * (i + 1));
         step();
         check_val("fill_count", 32'(count_a), 32'(i + 1));
      end
      in_a.valid = 1'b0;
      check_val("fill_in_ready", 32'(in_a.ready), 32'd0);
      check_val("fill_max", 32'(max_a), 32'd4);
      out_a.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_val("drain_valid", 32'(out_a.valid), 32'd1);
         step();
      end
      check_val("drain_empty_valid", 32'(out_a.valid), 32'd0);
      check_val("drain_count", 32'(count_a), 32'd0);

      // Streaming with pointer wrap
      do_reset();
      out_a.ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_a.valid = 1'b1;
         in_a.data  = 8'(i);
         step();
         check_val("stream_count", 32'(count_a), 32'd1);
      end
      in_a.valid = 1'b0;
      step();
      check_val("stream_end_count", 32'(count_a), 32'd0);
      check_val("stream_max", 32'(max_a), 32'd1);
      check_val("stream_q_empty", 32'(q_a.size()), 32'd0);

      // Full, no bypass
      do_reset();
      out_a.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_a.valid = 1'b1;
         in_a.data  = 8'(8'hC0 + i);
         step();
      end
      check_val("full_count", 32'(count_a), 32'd4);
      in_a.data   = 8'h55;
      out_a.ready = 1'b1;
      check_val("full_in_ready", 32'(in_a.ready), 32'd0);
      step();
      check_val("full_pop_count", 32'(count_a), 32'd3);
      check_val("full_ready_back", 32'(in_a.ready), 32'd1);
      step();
      check_val("full_both_count", 32'(count_a), 32'd3);
      in_a.valid = 1'b0;
      repeat (3) step();
      check_val("full_drain_count", 32'(count_a), 32'd0);
      check_val("full_q_empty", 32'(q_a.size()), 32'd0);

      // Reset mid-operation
      do_reset();
      out_a.ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_a.valid = 1'b1;
         in_a.data  = 8'(8'h70 + i);
         step();
      end
      in_a.valid = 1'b0;
      check_val("mid_count_pre", 32'(count_a), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_out_valid", 32'(out_a.valid), 32'd0);
      check_val("mid_count", 32'(count_a), 32'd0);
      check_val("mid_max", 32'(max_a), 32'd0);
      check_val("mid_in_ready", 32'(in_a.ready), 32'd1);
      step();
      rst_n = 1'b1;
      q_a.delete();
      q_b.delete();
      in_a.valid  = 1'b1;
      in_a.data   = 8'hA5;
      out_a.ready = 1'b1;
      step();
      in_a.valid = 1'b0;
      check_val("mid_first_data", 32'(out_a.data), 32'hA5);
      step();
      check_val("mid_after_count", 32'(count_a), 32'd0);
      check_val("mid_q_empty", 32'(q_a.size()), 32'd0);

      // Wide/deep instance
      out_b.ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_b.valid = 1'b1;
         in_b.data  = 32'h1357_9BDF * (i + 1);
         step();
      end
      in_b.valid = 1'b0;
      check_val("b_full_count", 32'(count_b), 32'd8);
      check_val("b_in_ready", 32'(in_b.ready), 32'd0);
      check_val("b_max", 32'(max_b), 32'd8);
      out_b.ready = 1'b1;
      repeat (8) step();
      check_val("b_drain_count", 32'(count_b), 32'd0);
      check_val("b_q_empty", 32'(q_b.size()), 32'd0);
      check_val("b_max_sticky", 32'(max_b), 32'd8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
